// File: rtl/loom_axil_mux_if.sv
// AXI-Lite bundle for N ports packed side by side; port i owns slice i of every field.
// master drives requests and response-ready, slave drives request-ready and responses.
interface loom_axil_mux_if #(
    parameter int N          = 1,
    parameter int ADDR_WIDTH = 20
);
    logic [N*ADDR_WIDTH-1:0] araddr;
    logic [N-1:0]            arvalid;
    logic [N-1:0]            arready;
    logic [N*32-1:0]         rdata;
    logic [N*2-1:0]          rresp;
    logic [N-1:0]            rvalid;
    logic [N-1:0]            rready;
    logic [N*ADDR_WIDTH-1:0] awaddr;
    logic [N-1:0]            awvalid;
    logic [N-1:0]            awready;
    logic [N*32-1:0]         wdata;
    logic [N*4-1:0]          wstrb;
    logic [N-1:0]            wvalid;
    logic [N-1:0]            wready;
    logic [N*2-1:0]          bresp;
    logic [N-1:0]            bvalid;
    logic [N-1:0]            bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/loom_axil_mux.sv
// N:1 AXI-Lite mux, independent round-robin read and write arbiters, one transaction in flight per channel.
// Latency: one cycle of arbitration, then address/data/response pass combinationally to the granted port.
// Backpressure: downstream ready/valid forwarded only to the granted port; other ports stall with requests held.
module loom_axil_mux #(
    parameter int ADDR_WIDTH = 20,
    parameter int N_SLAVES   = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    loom_axil_mux_if.slave   s_axil,
    loom_axil_mux_if.master  m_axil
);

    localparam int GW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ADDR,
        RD_RESP
    } rd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_XFER,
        WR_RESP
    } wr_state_t;

    rd_state_t           rd_state;
    wr_state_t           wr_state;
    logic [GW-1:0]       rd_gnt;
    logic [GW-1:0]       rd_ptr;
    logic [GW-1:0]       wr_gnt;
    logic [GW-1:0]       wr_ptr;
    logic                aw_done;
    logic                w_done;
    logic [N_SLAVES-1:0] rd_sel;
    logic [N_SLAVES-1:0] wr_sel;
    logic                ar_hs;
    logic                r_hs;
    logic                aw_hs;
    logic                w_hs;
    logic                b_hs;

    // Scan downward so the nearest requester after the pointer is the last one written.
    function automatic logic [GW-1:0] rr_pick(input logic [N_SLAVES-1:0] req,
                                              input logic [GW-1:0]       ptr);
        logic [GW-1:0] pick;
        int            idx;
        pick = ptr;
        for (int k = N_SLAVES; k >= 1; k--) begin
            idx = (int'(ptr) + k) % N_SLAVES;
            if (req[idx]) begin
                pick = GW'(idx);
            end
        end
        return pick;
    endfunction

    assign rd_sel = N_SLAVES'(1) << rd_gnt;
    assign wr_sel = N_SLAVES'(1) << wr_gnt;

    assign ar_hs = m_axil.arvalid && m_axil.arready;
    assign r_hs  = m_axil.rvalid  && m_axil.rready;
    assign aw_hs = m_axil.awvalid && m_axil.awready;
    assign w_hs  = m_axil.wvalid  && m_axil.wready;
    assign b_hs  = m_axil.bvalid  && m_axil.bready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_state <= RD_IDLE;
            rd_gnt   <= '0;
            rd_ptr   <= '0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (|s_axil.arvalid) begin
                        rd_gnt   <= rr_pick(s_axil.arvalid, rd_ptr);
                        rd_state <= RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    if (ar_hs) begin
                        rd_ptr   <= rd_gnt;
                        rd_state <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (r_hs) begin
                        rd_state <= RD_IDLE;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_state <= WR_IDLE;
            wr_gnt   <= '0;
            wr_ptr   <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            case (wr_state)
                WR_IDLE: begin
                    if (|s_axil.awvalid) begin
                        wr_gnt   <= rr_pick(s_axil.awvalid, wr_ptr);
                        wr_state <= WR_XFER;
                    end
                end
                WR_XFER: begin
                    if (aw_hs) begin
                        aw_done <= 1'b1;
                        wr_ptr  <= wr_gnt;
                    end
                    if (w_hs) begin
                        w_done <= 1'b1;
                    end
                    // Both beats may complete in the same cycle, so look at the handshakes too.
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        wr_state <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (b_hs) begin
                        aw_done  <= 1'b0;
                        w_done   <= 1'b0;
                        wr_state <= WR_IDLE;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    // Read path: address/data muxed by grant, handshakes qualified by state.
    assign m_axil.araddr  = s_axil.araddr[int'(rd_gnt)*ADDR_WIDTH +: ADDR_WIDTH];
    assign m_axil.arvalid = (rd_state == RD_ADDR) && s_axil.arvalid[rd_gnt];
    assign m_axil.rready  = (rd_state == RD_RESP) && s_axil.rready[rd_gnt];
    assign s_axil.arready = rd_sel & {N_SLAVES{(rd_state == RD_ADDR) && m_axil.arready}};
    assign s_axil.rvalid  = rd_sel & {N_SLAVES{(rd_state == RD_RESP) && m_axil.rvalid}};
    assign s_axil.rdata   = {N_SLAVES{m_axil.rdata}};
    assign s_axil.rresp   = {N_SLAVES{m_axil.rresp}};

    // Write path: AW and W each stop forwarding once their own beat has gone through.
    assign m_axil.awaddr  = s_axil.awaddr[int'(wr_gnt)*ADDR_WIDTH +: ADDR_WIDTH];
    assign m_axil.wdata   = s_axil.wdata[int'(wr_gnt)*32 +: 32];
    assign m_axil.wstrb   = s_axil.wstrb[int'(wr_gnt)*4 +: 4];
    assign m_axil.awvalid = (wr_state == WR_XFER) && !aw_done && s_axil.awvalid[wr_gnt];
    assign m_axil.wvalid  = (wr_state == WR_XFER) && !w_done && s_axil.wvalid[wr_gnt];
    assign m_axil.bready  = (wr_state == WR_RESP) && s_axil.bready[wr_gnt];
    assign s_axil.awready = wr_sel & {N_SLAVES{(wr_state == WR_XFER) && !aw_done && m_axil.awready}};
    assign s_axil.wready  = wr_sel & {N_SLAVES{(wr_state == WR_XFER) && !w_done && m_axil.wready}};
    assign s_axil.bvalid  = wr_sel & {N_SLAVES{(wr_state == WR_RESP) && m_axil.bvalid}};
    assign s_axil.bresp   = {N_SLAVES{m_axil.bresp}};

    // An initiator that drops arvalid while granted breaks the AXI contract.
    ar_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
                              (rd_state == RD_ADDR) |-> s_axil.arvalid[rd_gnt]);

endmodule

// File: tb/tb_loom_axil_mux.sv
// Bench for loom_axil_mux with two upstream ports: table-driven and random reads against a round-robin model,
// plus hand-written write, concurrency, error-response and reset sequences.
module tb_loom_axil_mux;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;

    int checks = 0;
    int errors = 0;

    loom_axil_mux_if #(.N(2), .ADDR_WIDTH(20)) s_if ();
    loom_axil_mux_if #(.N(1), .ADDR_WIDTH(20)) m_if ();

    loom_axil_mux #(.ADDR_WIDTH(20), .N_SLAVES(2)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .s_axil (s_if),
        .m_axil (m_if)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  req;
        int          exp;
        logic [31:0] rd;
        logic [1:0]  resp;
    } rd_vec_t;

    rd_vec_t     tbl[9];
    logic [1:0]  pend = 2'b00;
    int          rr_ptr = 0;
    logic [19:0] rd_addr[2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arbiter: first requester at or after (ptr+1) mod 2.
    function automatic int model_pick(input logic [1:0] req, input int ptr);
        for (int k = 1; k <= 2; k++) begin
            int idx;
            idx = (ptr + k) % 2;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic do_read(input logic [1:0] newreq, input int exp, input logic [31:0] rd,
                           input logic [1:0] resp, input bit rnd_addr,
                           input int ar_dly, input int r_dly, input bit bp);
        bit seen;
        for (int i = 0; i < 2; i++) begin
            if (newreq[i] && !pend[i]) begin
                pend[i]    = 1'b1;
                rd_addr[i] = rnd_addr ? 20'($urandom) : (i == 1 ? 20'h00040 : 20'h01000);
                s_if.araddr[i*20 +: 20] = rd_addr[i];
            end
        end
        s_if.arvalid  = pend;
        m_if.arready  = 1'b0;
        m_if.rvalid   = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            @(negedge clk_i); #1;
            seen = m_if.arvalid;
        end
        chk("ar_grant_seen", 64'(seen), 64'd1);
        if (!seen) return;
        chk("ar_addr", 64'(m_if.araddr), 64'(rd_addr[exp]));
        repeat (ar_dly) begin
            chk("ar_wait_rdy", 64'(s_if.arready), 64'd0);
            @(negedge clk_i); #1;
        end
        m_if.arready = 1'b1; #1;
        chk("ar_ready_grant", 64'(s_if.arready), 64'(1 << exp));
        @(negedge clk_i);
        m_if.arready  = 1'b0;
        pend[exp]     = 1'b0;
        s_if.arvalid  = pend; #1;
        chk("ar_stop", 64'(m_if.arvalid), 64'd0);
        repeat (r_dly) @(negedge clk_i);
        m_if.rdata   = rd;
        m_if.rresp   = resp;
        m_if.rvalid  = 1'b1;
        s_if.rready  = bp ? 2'b00 : 2'b11; #1;
        chk("r_valid_grant", 64'(s_if.rvalid), 64'(1 << exp));
        chk("r_data", 64'(s_if.rdata[exp*32 +: 32]), 64'(rd));
        chk("r_resp", 64'(s_if.rresp[exp*2 +: 2]), 64'(resp));
        if (bp) begin
            chk("r_backpressure", 64'(m_if.rready), 64'd0);
            @(negedge clk_i);
            s_if.rready = 2'b11; #1;
            chk("r_hold", 64'(s_if.rvalid), 64'(1 << exp));
        end
        chk("r_rready", 64'(m_if.rready), 64'd1);
        @(negedge clk_i);
        m_if.rvalid = 1'b0; #1;
        chk("r_done", 64'(s_if.rvalid), 64'd0);
        rr_ptr = exp;
    endtask

    task automatic do_write(input int port, input logic [19:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] resp, input int w_lead);
        m_if.awready = 1'b0;
        m_if.wready  = 1'b0;
        s_if.wdata[port*32 +: 32] = data;
        s_if.wstrb[port*4 +: 4]   = strb;
        s_if.wvalid[port]         = 1'b1;
        repeat (w_lead) begin
            @(negedge clk_i); #1;
            chk("w_early_held", 64'(m_if.wvalid), 64'd0);
        end
        s_if.awaddr[port*20 +: 20] = addr;
        s_if.awvalid[port]         = 1'b1;
        @(negedge clk_i); #1;
        chk("wr_awvalid", 64'(m_if.awvalid), 64'd1);
        chk("wr_wvalid", 64'(m_if.wvalid), 64'd1);
        chk("wr_awaddr", 64'(m_if.awaddr), 64'(addr));
        chk("wr_wdata", 64'(m_if.wdata), 64'(data));
        chk("wr_wstrb", 64'(m_if.wstrb), 64'(strb));
        m_if.wready = 1'b1; #1;
        chk("wr_wready", 64'(s_if.wready), 64'(1 << port));
        chk("wr_awready_low", 64'(s_if.awready), 64'd0);
        @(negedge clk_i);
        s_if.wvalid[port] = 1'b0;
        m_if.wready       = 1'b0; #1;
        chk("wr_w_stopped", 64'(m_if.wvalid), 64'd0);
        chk("wr_aw_pending", 64'(m_if.awvalid), 64'd1);
        m_if.awready = 1'b1; #1;
        chk("wr_awready", 64'(s_if.awready), 64'(1 << port));
        @(negedge clk_i);
        s_if.awvalid[port] = 1'b0;
        m_if.awready       = 1'b0;
        m_if.bresp         = resp;
        m_if.bvalid        = 1'b1; #1;
        chk("b_valid_grant", 64'(s_if.bvalid), 64'(1 << port));
        chk("b_resp", 64'(s_if.bresp[port*2 +: 2]), 64'(resp));
        chk("b_bready", 64'(m_if.bready), 64'd1);
        @(negedge clk_i);
        m_if.bvalid = 1'b0; #1;
        chk("b_done", 64'(s_if.bvalid), 64'd0);
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_s_ready"}, 64'({s_if.arready, s_if.awready, s_if.wready}), 64'd0);
        chk({nm, "_s_valid"}, 64'({s_if.rvalid, s_if.bvalid}), 64'd0);
        chk({nm, "_m_out"}, 64'({m_if.arvalid, m_if.rready, m_if.awvalid, m_if.wvalid, m_if.bready}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{2'b11, 1, 32'h12345678, 2'b00};
        tbl[1] = '{2'b00, 0, 32'h0000_0001, 2'b00};
        tbl[2] = '{2'b11, 1, 32'hDEAD_BEEF, 2'b10};
        tbl[3] = '{2'b10, 0, 32'h0BAD_F00D, 2'b00};
        tbl[4] = '{2'b00, 1, 32'h5555_AAAA, 2'b11};
        tbl[5] = '{2'b01, 0, 32'h0000_0000, 2'b00};
        tbl[6] = '{2'b01, 0, 32'hFFFF_FFFF, 2'b01};
        tbl[7] = '{2'b10, 1, 32'h1357_9BDF, 2'b00};
        tbl[8] = '{2'b10, 1, 32'h2468_ACE0, 2'b10};

        s_if.araddr = '0; s_if.arvalid = '0; s_if.rready = 2'b11;
        s_if.awaddr = '0; s_if.awvalid = '0; s_if.wdata = '0; s_if.wstrb = '0;
        s_if.wvalid = '0; s_if.bready = 2'b11;
        m_if.arready = 1'b0; m_if.rdata = '0; m_if.rresp = '0; m_if.rvalid = 1'b0;
        m_if.awready = 1'b0; m_if.wready = 1'b0; m_if.bresp = '0; m_if.bvalid = 1'b0;

        repeat (2) @(negedge clk_i);
        #1 chk_quiet("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i); #1;
        chk_quiet("idle");

        // Table: hand-derived round-robin order, pending losers carried over.
        foreach (tbl[i]) begin
            do_read(tbl[i].req, tbl[i].exp, tbl[i].rd, tbl[i].resp, 1'b0, i % 2, i % 3, i == 4);
        end

        for (int it = 0; it < 60; it++) begin
            logic [1:0] nr;
            int         exp;
            nr = 2'($urandom_range(0, 3));
            if ((pend | nr) == 2'b00) nr = 2'b01;
            exp = model_pick(pend | nr, rr_ptr);
            do_read(nr, exp, $urandom, 2'($urandom_range(0, 3)), 1'b1,
                    $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end
        while (pend != 2'b00) begin
            do_read(2'b00, model_pick(pend, rr_ptr), $urandom, 2'b00, 1'b1, 0, 0, 1'b0);
        end

        do_write(0, 20'h00ABC, 32'hCAFE_F00D, 4'hF, 2'b00, 2);
        do_write(1, 20'h00100, 32'h0000_BEEF, 4'h3, 2'b10, 0);

        // Read on port 0 and write on port 1 in flight together.
        s_if.araddr[19:0]  = 20'h00123;
        s_if.arvalid       = 2'b01;
        s_if.awaddr[39:20] = 20'h00456;
        s_if.wdata[63:32]  = 32'hA5A5_0001;
        s_if.wstrb[7:4]    = 4'h3;
        s_if.awvalid       = 2'b10;
        s_if.wvalid        = 2'b10;
        @(negedge clk_i); #1;
        chk("cc_all_valid", 64'({m_if.arvalid, m_if.awvalid, m_if.wvalid}), 64'h7);
        chk("cc_araddr", 64'(m_if.araddr), 64'h00123);
        chk("cc_awaddr", 64'(m_if.awaddr), 64'h00456);
        m_if.arready = 1'b1; m_if.awready = 1'b1; m_if.wready = 1'b1; #1;
        chk("cc_arready", 64'(s_if.arready), 64'h1);
        chk("cc_aw_w_ready", 64'({s_if.awready, s_if.wready}), 64'hA);
        @(negedge clk_i);
        s_if.arvalid = '0; s_if.awvalid = '0; s_if.wvalid = '0;
        m_if.arready = 1'b0; m_if.awready = 1'b0; m_if.wready = 1'b0;
        m_if.rdata = 32'h7777_0000; m_if.rresp = 2'b00; m_if.rvalid = 1'b1;
        m_if.bresp = 2'b00; m_if.bvalid = 1'b1; #1;
        chk("cc_rvalid", 64'(s_if.rvalid), 64'h1);
        chk("cc_bvalid", 64'(s_if.bvalid), 64'h2);
        @(negedge clk_i);
        m_if.rvalid = 1'b0; m_if.bvalid = 1'b0; #1;
        chk("cc_done", 64'({s_if.rvalid, s_if.bvalid}), 64'h0);
        rr_ptr = 0;

        // Reset asserted while a write response is being offered.
        s_if.awaddr[19:0] = 20'h00020; s_if.wdata[31:0] = 32'h1; s_if.wstrb[3:0] = 4'hF;
        s_if.awvalid = 2'b01; s_if.wvalid = 2'b01;
        m_if.awready = 1'b1; m_if.wready = 1'b1;
        repeat (2) @(negedge clk_i);
        s_if.awvalid = '0; s_if.wvalid = '0;
        m_if.awready = 1'b0; m_if.wready = 1'b0;
        m_if.bresp = 2'b00; m_if.bvalid = 1'b1; #1;
        chk("rst_b_before", 64'(s_if.bvalid), 64'h1);
        #2 rst_ni = 1'b0;
        #1 chk_quiet("rst_mid");
        m_if.bvalid = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        rr_ptr = 0;
        do_read(2'b11, model_pick(2'b11, rr_ptr), 32'h0F0F_0F0F, 2'b00, 1'b1, 0, 1, 1'b0);
        while (pend != 2'b00) begin
            do_read(2'b00, model_pick(pend, rr_ptr), $urandom, 2'b00, 1'b1, 1, 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
